array_mult_4bit: RTL and testbench

- Unsigned 4x4 array multiplier producing an 8-bit product.
- Built as a carry-save array of AND-gate partial products and full/half adders with a ripple final row.
- Operands are captured from combinational inputs; the product is presented on a registered output in the datapath clock domain.
- Used as a small arithmetic leaf inside larger datapaths.

---
 rtl/array_mult_pkg.sv | 11 +
 rtl/array_mult_4bit_full_adder.sv | 20 ++
 rtl/array_mult_4bit.sv | 131 +++++++++++++
 tb/tb_array_mult_4bit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/array_mult_pkg.sv
// Shared widths and types for the 4x4 unsigned array multiplier.
// Partial-product matrix is indexed [row = b bit][column = a bit].
package array_mult_pkg;

    localparam int MULT_W = 4;
    localparam int PROD_W = 8;

    typedef logic [MULT_W-1:0][MULT_W-1:0] pp_mat_t;
    typedef logic [PROD_W-1:0]             prod_t;

endpackage

// File: rtl/array_mult_4bit_full_adder.sv
// One-bit full adder cell; a half adder is this cell with cin tied low.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module full_adder
    import array_mult_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign sum      = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/array_mult_4bit.sv
// Unsigned 4x4 carry-save array multiplier with registered 8-bit product.
// Latency: 1 cycle; 2 cycles when ARRAY_MULT_PIPE_EN adds a stage after row 2.
// Backpressure: none; accepts one operand pair per cycle, prod qualified by out_valid.
module array_mult_4bit
    import array_mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 out_valid
);

    if (WIDTH != MULT_W) begin : g_width_check
        $error("array_mult_4bit: only WIDTH = 4 is supported");
    end

    pp_mat_t            pp;
    prod_t              prod_d;

    // s_k bit j carries weight k+j; c_k bit j carries weight k+j+1.
    logic [MULT_W-1:0]  s0, s1, s2, s3;
    logic [MULT_W-2:0]  c1, c2, c3;

    // Values crossing the optional row-2 boundary.
    logic [MULT_W-1:0]  s2_q;
    logic [MULT_W-2:0]  c2_q;
    logic [1:0]         lo_q;
    logic [MULT_W-1:0]  a_q;
    logic               b3_q;
    logic               vld_q;

    logic p4, p5, p6, p7;
    logic r4, r5;

    always_comb begin
        pp = '0;
        for (int i = 0; i < MULT_W - 1; i++) begin
            for (int j = 0; j < MULT_W; j++) begin
                pp[i][j] = a[j] & b[i];
            end
        end
        for (int j = 0; j < MULT_W; j++) begin
            pp[MULT_W-1][j] = a_q[j] & b3_q;
        end
    end

    assign s0 = pp[0];

    for (genvar j = 0; j < MULT_W - 1; j++) begin : g_row1
        full_adder u_fa (
            .a    (pp[1][j]),
            .b    (s0[j+1]),
            .cin  (1'b0),
            .sum  (s1[j]),
            .cout (c1[j])
        );
    end
    assign s1[MULT_W-1] = pp[1][MULT_W-1];

    for (genvar j = 0; j < MULT_W - 1; j++) begin : g_row2
        full_adder u_fa (
            .a    (pp[2][j]),
            .b    (s1[j+1]),
            .cin  (c1[j]),
            .sum  (s2[j]),
            .cout (c2[j])
        );
    end
    assign s2[MULT_W-1] = pp[2][MULT_W-1];

`ifdef ARRAY_MULT_PIPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q  <= '0;
            c2_q  <= '0;
            lo_q  <= '0;
            a_q   <= '0;
            b3_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            s2_q  <= s2;
            c2_q  <= c2;
            lo_q  <= {s1[0], s0[0]};
            a_q   <= a;
            b3_q  <= b[MULT_W-1];
            vld_q <= in_valid;
        end
    end
`else
    assign s2_q  = s2;
    assign c2_q  = c2;
    assign lo_q  = {s1[0], s0[0]};
    assign a_q   = a;
    assign b3_q  = b[MULT_W-1];
    assign vld_q = in_valid;
`endif

    for (genvar j = 0; j < MULT_W - 1; j++) begin : g_row3
        full_adder u_fa (
            .a    (pp[3][j]),
            .b    (s2_q[j+1]),
            .cin  (c2_q[j]),
            .sum  (s3[j]),
            .cout (c3[j])
        );
    end
    assign s3[MULT_W-1] = pp[3][MULT_W-1];

    // Ripple row resolves the remaining sum/carry pairs into bits 7..4.
    full_adder u_cpa4 (.a(s3[1]), .b(c3[0]), .cin(1'b0), .sum(p4), .cout(r4));
    full_adder u_cpa5 (.a(s3[2]), .b(c3[1]), .cin(r4),   .sum(p5), .cout(r5));
    full_adder u_cpa6 (.a(s3[3]), .b(c3[2]), .cin(r5),   .sum(p6), .cout(p7));

    assign prod_d = {p7, p6, p5, p4, s3[0], s2_q[0], lo_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod      <= '0;
            out_valid <= 1'b0;
        end else begin
            prod      <= prod_d;
            out_valid <= vld_q;
        end
    end

endmodule

// File: tb/tb_array_mult_4bit.sv
// Directed and streamed checks of array_mult_4bit, latency-aware for ARRAY_MULT_PIPE_EN.
module tb_array_mult_4bit;

`ifdef ARRAY_MULT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [7:0] prod;
    logic       out_valid;

    int total;
    int bad;

    logic [3:0] va [256];
    logic [3:0] vb [256];

    array_mult_4bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .prod      (prod),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic apply(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                         input logic v, input logic [7:0] exp);
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        in_valid = v;
        repeat (LAT) @(posedge clk);
        #1;
        chk({tag, "_vld"}, {31'd0, out_valid}, {31'd0, v});
        if (v) chk({tag, "_prod"}, {24'd0, prod}, {24'd0, exp});
    endtask

    task automatic run_stream(input string tag, input int n);
        int k;
        int e;
        for (int t = 0; t < n + LAT - 1; t++) begin
            @(negedge clk);
            if (t < n) begin
                a        = va[t];
                b        = vb[t];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (t >= LAT - 1) begin
                k = t - LAT + 1;
                e = int'(va[k]) * int'(vb[k]);
                chk($sformatf("%s_prod_%0d", tag, k), {24'd0, prod}, e);
                chk($sformatf("%s_vld_%0d", tag, k), {31'd0, out_valid}, 32'd1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;

        #3;
        chk("reset_prod", {24'd0, prod}, 32'h00);
        chk("reset_vld", {31'd0, out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        apply("d_9",  4'hD, 4'h9, 1'b1, 8'h75);
        apply("0_f",  4'h0, 4'hF, 1'b1, 8'h00);
        apply("a_5",  4'hA, 4'h5, 1'b1, 8'h32);
        apply("c_3",  4'hC, 4'h3, 1'b1, 8'h24);
        apply("a_d",  4'hA, 4'hD, 1'b1, 8'h82);
        apply("8_0",  4'h8, 4'h0, 1'b1, 8'h00);
        apply("f_f",  4'hF, 4'hF, 1'b1, 8'hE1);
        apply("1_f",  4'h1, 4'hF, 1'b1, 8'h0F);
        apply("f_1",  4'hF, 4'h1, 1'b1, 8'h0F);
        apply("gate", 4'h3, 4'h3, 1'b0, 8'h09);

        // Asynchronous reset asserted mid-cycle while a valid result is held.
        apply("pre_rst", 4'hD, 4'h9, 1'b1, 8'h75);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_prod", {24'd0, prod}, 32'h00);
        chk("async_rst_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 4'h7, 4'h6, 1'b1, 8'h2A);

        for (int i = 0; i < 16; i++) begin
            va[i] = 4'(i);
            vb[i] = 4'(15 - i);
        end
        run_stream("stream", 16);

        for (int i = 0; i < 256; i++) begin
            va[i] = 4'(i >> 4);
            vb[i] = 4'(i & 15);
        end
        run_stream("exh", 256);

        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("drain_vld", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
